// File: rtl/watch_fnd_ctrl.sv
// Four-digit multiplexed 7-segment driver for the stopwatch/clock datapath.
// Inputs are snapshotted at each frame boundary, so every 4-digit frame is self-consistent.
module watch_fnd_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_disp_sel,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  function automatic digit_t next_digit(input digit_t d);
    case (d)
      DIG0:    return DIG1;
      DIG1:    return DIG2;
      DIG2:    return DIG3;
      default: return DIG0;
    endcase
  endfunction

  function automatic logic [7:0] seg7(input logic [6:0] v);
    case (v)
      7'd0:    return 8'hC0;
      7'd1:    return 8'hF9;
      7'd2:    return 8'hA4;
      7'd3:    return 8'hB0;
      7'd4:    return 8'h99;
      7'd5:    return 8'h92;
      7'd6:    return 8'h82;
      7'd7:    return 8'hF8;
      7'd8:    return 8'h80;
      7'd9:    return 8'h90;
      default: return SEG_OFF;
    endcase
  endfunction

  logic [PW-1:0] r_presc;
  logic          w_tick;
  digit_t        r_idx;

  logic [6:0]    r_snap_msec;
  logic [5:0]    r_snap_sec;
  logic [5:0]    r_snap_min;
  logic [4:0]    r_snap_hour;
  logic          r_snap_sel;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= DIG0;
    end else if (w_tick) begin
      r_idx <= next_digit(r_idx);
    end
  end

  // Snapshot on the same edge that wraps idx 3 -> 0, so digit 0 of the new frame already sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_msec <= '0;
      r_snap_sec  <= '0;
      r_snap_min  <= '0;
      r_snap_hour <= '0;
      r_snap_sel  <= 1'b0;
    end else if (w_tick && (r_idx == DIG3)) begin
      r_snap_msec <= i_msec;
      r_snap_sec  <= i_sec;
      r_snap_min  <= i_min;
      r_snap_hour <= i_hour;
      r_snap_sel  <= i_disp_sel;
    end
  end

  logic [6:0] w_hi_val;
  logic       w_hi_bad;
  logic [6:0] w_lo_val;
  logic       w_lo_bad;
  logic [6:0] w_field;
  logic       w_bad;
  logic [6:0] w_tens;
  logic [6:0] w_ones;
  logic [6:0] w_digit;
  logic       w_dp;
  logic [7:0] w_data;
  logic [3:0] w_com;

  always_comb begin
    w_hi_val = '0;
    w_hi_bad = 1'b0;
    w_lo_val = '0;
    w_lo_bad = 1'b0;
    if (r_snap_sel) begin
      w_hi_val = {1'b0, r_snap_sec};
      w_hi_bad = (r_snap_sec > 6'd59);
      w_lo_val = r_snap_msec;
      w_lo_bad = (r_snap_msec > 7'd99);
    end else begin
      w_hi_val = {2'b00, r_snap_hour};
      w_hi_bad = (r_snap_hour > 5'd23);
      w_lo_val = {1'b0, r_snap_min};
      w_lo_bad = (r_snap_min > 6'd59);
    end
  end

  always_comb begin
    w_field = '0;
    w_bad   = 1'b0;
    w_digit = '0;
    w_dp    = 1'b0;
    w_data  = SEG_OFF;

    if ((r_idx == DIG3) || (r_idx == DIG2)) begin
      w_field = w_hi_val;
      w_bad   = w_hi_bad;
    end else begin
      w_field = w_lo_val;
      w_bad   = w_lo_bad;
    end

    w_tens  = w_field / 7'd10;
    w_ones  = w_field % 7'd10;
    w_digit = ((r_idx == DIG3) || (r_idx == DIG1)) ? w_tens : w_ones;

    // Page 0 blinks the colon dot at 1 Hz off the centisecond field; page 1 keeps it lit.
    w_dp   = (r_idx == DIG2) && (r_snap_sel || (r_snap_msec < 7'd50));
    w_data = w_bad ? SEG_DASH : seg7(w_digit);
    if (w_dp) begin
      w_data[7] = 1'b0;
    end
  end

  assign w_com = ~(4'b0001 << r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fnd_com  <= '1;
      fnd_data <= '1;
    end else begin
      fnd_com  <= w_com;
      fnd_data <= w_data;
    end
  end

endmodule
